// File: rtl/seq_mult_32_bit.sv
// seq_mult_32_bit
// Iterative shift-and-add WIDTH x WIDTH -> 2*WIDTH multiplier. The adder is
// external and shared: this block drives its operands each RUN cycle and
// folds the returned sum/carry into the product register.
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN: it adds an
// is_signed input and a one-cycle NEG state that applies the result sign.
module seq_mult_32_bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic [2*WIDTH-1:0] prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

`ifdef SEQ_MULT_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, NEG} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] p_reg, p_next;
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               last_iter;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_reg, sign_next;
  logic smode_reg, smode_next;

  // Operand magnitudes for signed capture; the negate is local, not the shared adder
  always_comb begin
    mag_a = op_a;
    mag_b = op_b;
    if (is_signed && op_a[WIDTH-1]) mag_a = ~op_a + WIDTH'(1);
    if (is_signed && op_b[WIDTH-1]) mag_b = ~op_b + WIDTH'(1);
  end
`else
  assign mag_a = op_a;
  assign mag_b = op_b;
`endif

  // Final RUN edge is the one where the counter has already seen WIDTH-1 steps
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // State, counter, product and multiplicand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      p_reg     <= '0;
      m_reg     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_reg  <= 1'b0;
      smode_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      m_reg     <= m_next;
`ifdef SEQ_MULT_SIGNED_EN
      sign_reg  <= sign_next;
      smode_reg <= smode_next;
`endif
    end
  end

  // Next-state logic, adder drive and output decode
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    m_next     = m_reg;
`ifdef SEQ_MULT_SIGNED_EN
    sign_next  = sign_reg;
    smode_next = smode_reg;
`endif
    busy       = (state_reg != IDLE);
    out_valid  = 1'b0;
    prod       = '0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = mag_a;
          p_next     = {{WIDTH{1'b0}}, mag_b};
          cnt_next   = '0;
          state_next = RUN;
`ifdef SEQ_MULT_SIGNED_EN
          smode_next = is_signed;
          sign_next  = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`endif
        end
      end

      RUN: begin
        // Upper half plus (multiplicand if current multiplier bit set)
        add_a    = p_reg[2*WIDTH-1:WIDTH];
        add_b    = p_reg[0] ? m_reg : '0;
        // Shift {carry, sum, lower half} right by one into P
        p_next   = {add_cout, add_sum, p_reg[WIDTH-1:1]};
        cnt_next = cnt_reg + CNT_W'(1);
        if (last_iter) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_next = smode_reg ? NEG : DONE;
`else
          state_next = DONE;
`endif
        end
      end

`ifdef SEQ_MULT_SIGNED_EN
      NEG: begin
        // Always one cycle so signed latency does not depend on the sign
        if (sign_reg) p_next = ~p_reg + (2*WIDTH)'(1);
        state_next = DONE;
      end
`endif

      DONE: begin
        out_valid = 1'b1;
        prod      = p_reg;
        if (out_ready) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mult_32_bit.sv
// Directed testbench for seq_mult_32_bit with a behavioural model of the
// shared external adder.
module tb_seq_mult_32_bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_signed;
  logic        busy;
  logic [63:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [32:0] add_res;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_32_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External adder model
  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
  assign add_sum  = add_res[31:0];
  assign add_cout = add_res[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  64'(busy),      64'd0);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".prod"},  prod,           64'd0);
    check({tag, ".add_a"}, 64'(add_a),     64'd0);
    check({tag, ".add_b"}, 64'(add_b),     64'd0);
    check({tag, ".cin"},   64'(add_cin),   64'd0);
  endtask

  // One multiply: accept, wait for result with a bound, hold under
  // back-pressure, then hand off.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int exp_lat, input logic [63:0] exp_p,
                        input int hold, input bit chk_addb, input int poke_at);
    int  cyc;
    bit  addb_bad;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; is_signed = sgn;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    addb_bad = 0;
    while (!out_valid && cyc < 100) begin
      if (chk_addb && add_b !== 32'd0) addb_bad = 1;
      if (cyc == 1) begin
        check({tag, ".busy_run"}, 64'(busy), 64'd1);
        check({tag, ".prod_run"}, prod, 64'd0);
      end
      if (cyc == poke_at) begin
        start = 1'b1; op_a = 32'd3; op_b = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    if (chk_addb) check({tag, ".add_b_quiet"}, 64'(addb_bad), 64'd0);
    check({tag, ".prod"}, prod, exp_p);
    check({tag, ".done_add_a"}, 64'(add_a), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_prod"}, prod, exp_p);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".idle_prod"}, prod, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    is_signed = 1'b0; out_ready = 1'b0;
    #1;
    check_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("7x6", 32'd7, 32'd6, 1'b0, 32, 64'h0000_0000_0000_002A, 0, 0, -1);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 64'hFFFF_FFFE_0000_0001, 5, 0, -1);
    run_op("poke", 32'd12345, 32'd1000, 1'b0, 32, 64'd12345000, 0, 0, 10);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op_a = 32'd5; op_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    check("midrun.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("2x2", 32'd2, 32'd2, 1'b0, 32, 64'd4, 0, 0, -1);

    run_op("b0", 32'h8000_0000, 32'd0, 1'b0, 32, 64'd0, 0, 1, -1);
    run_op("a0", 32'd0, 32'd1, 1'b0, 32, 64'd0, 0, 1, -1);

`ifdef SEQ_MULT_SIGNED_EN
    run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 33, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, -1);
    run_op("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 33, 64'h4000_0000_0000_0000, 0, 0, -1);
    run_op("s_pos", 32'd9, 32'd11, 1'b1, 33, 64'd99, 0, 0, -1);
    run_op("u_in_s", 32'hFFFF_FFFD, 32'd5, 1'b0, 32, 64'h0000_0004_FFFF_FFF1, 0, 0, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_32_bit.md
Name: seq_mult_32_bit

Overview:
- Iterative shift-and-add 32x32 -> 64-bit multiplier for the KGP-RISC execute stage.
- Sits directly upstream of the shared 32-bit ripple-of-CLA adder. Each cycle it drives the adder's operand and carry inputs, then consumes its sum and carry-out.
- The adder instance lives outside this block, at ALU level. This block only sequences the operands and accumulates the result.
- Start/busy handshake on the input side; valid/ready handshake on the result side.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  32  multiplicand, captured on accepted start.
- op_b  in  32  multiplier, captured on accepted start.
- busy  out  1  high in every state other than IDLE.
- prod  out  64  product; valid only while out_valid=1.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- add_a  out  32  to adder input a.
- add_b  out  32  to adder input b.
- add_cin  out  1  to adder c_in; constant 0.
- add_sum  in  32  from adder sum.
- add_cout  in  1  from adder c_out.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, counter=0, product register P (64 bits)=0, multiplicand register M=0;
  - busy=0, out_valid=0, prod=0, add_a=0, add_b=0, add_cin=0.
- Reset asserted mid-operation aborts the multiply immediately; no partial result is presented.
- States: IDLE, RUN, DONE (plus NEG, optional feature only).
- IDLE:
  - start=1 at edge E0: M<=op_a, P<={32'b0, op_b}, counter<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, combinational adder drive:
  - add_a=P[63:32];
  - add_b = P[0] ? M : 0;
  - add_cin=0.
- RUN, each edge:
  - P <= {add_cout, add_sum, P[31:1]}, i.e. 65-bit right shift of {carry, sum, low half};
  - counter increments by 1.
- After the 32nd RUN edge (E32): state<=DONE, out_valid<=1.
- Unsigned latency: out_valid high 32 cycles after the start-accept edge. Latency is data-independent; zero operands still take 32 cycles.
- DONE:
  - prod=P, held stable while out_valid=1 and out_ready=0 (back-pressure, unlimited).
  - Edge with out_ready=1: out_valid<=0, state<=IDLE.
  - A new start is accepted no earlier than the cycle after return to IDLE; no same-cycle turnaround.
- start while busy=1 is ignored; no queuing, no corruption of the operation in flight.
- Outside RUN: add_a=0 and add_b=0, so the shared adder sees a quiet input.
- add_cout is consumed only in RUN.
- prod reads 0 in every state except DONE.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Extra input port is_signed (1 bit), sampled together with start.
  - When is_signed=1, op_a and op_b are converted to magnitudes at capture (local two's-complement negate) and a sign flag = op_a[31]^op_b[31] is stored.
  - After E32 the FSM enters NEG for exactly one edge: P <= sign ? (~P+1) : P, then DONE.
  - Signed latency is always 33 cycles, independent of sign.
  - is_signed=0 behaves exactly as unsigned (32 cycles).
  - The NEG negate uses local logic, not the shared adder; add_a and add_b are 0 in NEG.
- Undefined: no is_signed port, no NEG state; unsigned-only operation.

Test Plan:
- Reset, then start with op_a=7, op_b=6 -> out_valid rises exactly 32 cycles after the accept edge; prod=64'h0000_0000_0000_002A.
- op_a=op_b=32'hFFFF_FFFF, out_ready held 0 for 5 cycles -> prod=64'hFFFF_FFFE_0000_0001, stable all 5 cycles; with out_ready=1, out_valid falls next edge and busy=0.
- start pulsed again at RUN cycle 10 with op_a=3, op_b=3 -> ignored; first result (12345*1000=64'd12345000) delivered unchanged at cycle 32.
- rst_n dropped asynchronously mid-RUN at cycle 16 -> busy, out_valid, prod, add_a, add_b all 0 immediately; next start of 2*2 gives 4 after 32 cycles.
- op_b=0 and op_a=32'h8000_0000 -> add_b=0 on every RUN cycle; prod=0 after 32 cycles; op_a=0, op_b=1 also gives 0.
- SEQ_MULT_SIGNED_EN defined:
  - is_signed=1, op_a=-3, op_b=5 -> prod=64'hFFFF_FFFF_FFFF_FFF1 after 33 cycles;
  - is_signed=1, op_a=op_b=32'h8000_0000 -> prod=64'h4000_0000_0000_0000.
